// File: rtl/jtag_cmd_chain.sv
// JTAG user-chain to bus-command bridge with a read-return FIFO and sticky status.
// Optional macro JTAG_CHAIN_AUTOINC_EN: advance the address after every command handshake.
module jtag_cmd_chain #(
    parameter int DATA_W    = 32,
    parameter int BUF_DEPTH = 8,
    parameter int BURST_W   = 8
) (
    input  logic                  JTCK,
    input  logic                  JRSTN,
    input  logic                  JTDI,
    input  logic                  JSHIFT,
    input  logic                  JUPDATE,
    input  logic                  JCE,
    input  logic                  JRTI,
    output logic                  JTDO,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic                  cmd_write,
    output logic [DATA_W-1:0]     cmd_addr,
    output logic [DATA_W/8-1:0]   cmd_be,
    output logic [BURST_W-1:0]    cmd_burst,
    output logic [DATA_W-1:0]     cmd_wdata,
    input  logic                  rd_valid,
    input  logic [DATA_W-1:0]     rd_data
);

    localparam int SR_W = 4 + DATA_W;
    localparam int PW   = $clog2(BUF_DEPTH);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [3:0] {
        OP_ADDR   = 4'h1,
        OP_BE     = 4'h2,
        OP_BURST  = 4'h3,
        OP_WRITE  = 4'h4,
        OP_STATUS = 4'h8,
        OP_READ   = 4'h9,
        OP_POP    = 4'hA,
        OP_CLEAR  = 4'hF
    } opcode_e;

    logic [SR_W-1:0]    sr;
    logic [DATA_W-1:0]  cap_reg;
    logic [DATA_W-1:0]  addr_reg;
    logic [BE_W-1:0]    be_reg;
    logic [BURST_W-1:0] burst_reg;

    logic [DATA_W-1:0]  lat_addr;
    logic [BE_W-1:0]    lat_be;
    logic [BURST_W-1:0] lat_burst;
    logic [BURST_W-1:0] rd_left;

    logic [DATA_W-1:0]  mem [BUF_DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [PW:0]        count;
    logic               overflow;
    logic               underflow;
    logic               drop;

    opcode_e            op;
    logic [DATA_W-1:0]  payload;
    logic [BURST_W-1:0] eff_burst;
    logic [BURST_W-1:0] lat_eff_burst;
    logic               busy;
    logic               buf_empty;
    logic               buf_full;
    logic               handshake;
    logic               issue_req;
    logic               issue;
    logic               drop_evt;
    logic               push;
    logic               pop;
    logic               flush;
    logic               mem_we;
    logic [DATA_W-1:0]  status;

    assign op        = opcode_e'(sr[3:0]);
    assign payload   = sr[SR_W-1:4];
    assign JTDO      = sr[0];

    assign eff_burst     = (burst_reg == '0) ? BURST_W'(1) : burst_reg;
    assign lat_eff_burst = (lat_burst == '0) ? BURST_W'(1) : lat_burst;

    assign busy      = cmd_valid || (rd_left != '0);
    assign buf_empty = (count == '0);
    assign buf_full  = (count == (PW+1)'(BUF_DEPTH));
    assign handshake = cmd_valid && cmd_ready;

    assign issue_req = JUPDATE && JRTI && (op == OP_WRITE || op == OP_READ);
    assign issue     = issue_req && !busy;
    assign drop_evt  = issue_req && busy;
    assign push      = rd_valid;
    assign pop       = JUPDATE && (op == OP_POP);
    assign flush     = JUPDATE && (op == OP_CLEAR);

    // A pop in the same cycle frees a slot, so a full buffer still accepts that push.
    assign mem_we = push && !flush && (pop ? !buf_empty : !buf_full);

    assign status = DATA_W'({8'(count), 2'b00, overflow, underflow, drop,
                             buf_empty, buf_full, busy});

    // While a command is outstanding the latched copy is presented, so later
    // configuration updates cannot disturb a command mid-handshake.
    assign cmd_addr  = cmd_valid ? lat_addr  : addr_reg;
    assign cmd_be    = cmd_valid ? lat_be    : be_reg;
    assign cmd_burst = cmd_valid ? lat_burst : burst_reg;

    always_ff @(posedge JTCK) begin
        if (!JRSTN) begin
            sr <= '0;
        end else if (JCE) begin
            sr <= JSHIFT ? {JTDI, sr[SR_W-1:1]} : {cap_reg, 4'h0};
        end
    end

    always_ff @(posedge JTCK) begin
        if (!JRSTN) begin
            addr_reg  <= '0;
            be_reg    <= '1;
            burst_reg <= '0;
        end else begin
            if (JUPDATE && op == OP_ADDR) begin
                addr_reg <= payload;
`ifdef JTAG_CHAIN_AUTOINC_EN
            end else if (handshake) begin
                addr_reg <= addr_reg + DATA_W'(lat_eff_burst) * DATA_W'(BE_W);
`endif
            end
            if (JUPDATE && op == OP_BE) begin
                be_reg <= payload[BE_W-1:0];
            end
            if (JUPDATE && op == OP_BURST) begin
                burst_reg <= (payload[BURST_W-1:0] == '0) ? BURST_W'(1) : payload[BURST_W-1:0];
            end
        end
    end

    always_ff @(posedge JTCK) begin
        if (!JRSTN) begin
            cmd_valid <= 1'b0;
            cmd_write <= 1'b0;
            cmd_wdata <= '0;
            lat_addr  <= '0;
            lat_be    <= '1;
            lat_burst <= '0;
            rd_left   <= '0;
        end else if (issue) begin
            cmd_valid <= 1'b1;
            cmd_write <= (op == OP_WRITE);
            lat_addr  <= addr_reg;
            lat_be    <= be_reg;
            lat_burst <= burst_reg;
            rd_left   <= (op == OP_READ) ? eff_burst : '0;
            if (op == OP_WRITE) begin
                cmd_wdata <= payload;
            end
        end else begin
            if (handshake) begin
                cmd_valid <= 1'b0;
            end
            // Discarded overflow words still count toward burst completion.
            if (rd_valid && rd_left != '0) begin
                rd_left <= rd_left - 1'b1;
            end
        end
    end

    // NOTE: the buffer storage has no reset; the pointers and count define
    // which entries are meaningful, so clearing the array would only add logic.
    always_ff @(posedge JTCK) begin
        if (JRSTN && mem_we) begin
            mem[wr_ptr] <= rd_data;
        end
    end

    always_ff @(posedge JTCK) begin
        if (!JRSTN) begin
            cap_reg   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            drop      <= 1'b0;
        end else begin
            if (drop_evt) begin
                drop <= 1'b1;
            end
            if (flush) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                count     <= '0;
                overflow  <= 1'b0;
                underflow <= 1'b0;
                drop      <= 1'b0;
            end else begin
                case ({push, pop})
                    2'b10: begin
                        if (buf_full) begin
                            overflow <= 1'b1;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                            count  <= count + 1'b1;
                        end
                    end
                    2'b01: begin
                        if (buf_empty) begin
                            underflow <= 1'b1;
                            cap_reg   <= '0;
                        end else begin
                            cap_reg <= mem[rd_ptr];
                            rd_ptr  <= rd_ptr + 1'b1;
                            count   <= count - 1'b1;
                        end
                    end
                    2'b11: begin
                        // Empty buffer: the arriving word bypasses storage straight to the pop.
                        if (buf_empty) begin
                            cap_reg <= rd_data;
                        end else begin
                            cap_reg <= mem[rd_ptr];
                            rd_ptr  <= rd_ptr + 1'b1;
                            wr_ptr  <= wr_ptr + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            if (JUPDATE && op == OP_STATUS) begin
                cap_reg <= status;
            end
        end
    end

endmodule

// File: tb/tb_jtag_cmd_chain.sv
// Directed bench for jtag_cmd_chain: scans opcodes through the user chain and
// compares bus outputs and captured words against hand-computed values.
module tb_jtag_cmd_chain;

    logic        JTCK = 1'b0;
    logic        JRSTN, JTDI, JSHIFT, JUPDATE, JCE, JRTI;
    logic        JTDO;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_be;
    logic [7:0]  cmd_burst;
    logic [31:0] cmd_wdata;
    logic        rd_valid;
    logic [31:0] rd_data;

    int n_checks = 0;
    int n_pass   = 0;
    int hs_count = 0;
    int hs_base;

    logic [35:0] cap;
    logic [35:0] junk;

    jtag_cmd_chain dut (
        .JTCK      (JTCK),
        .JRSTN     (JRSTN),
        .JTDI      (JTDI),
        .JSHIFT    (JSHIFT),
        .JUPDATE   (JUPDATE),
        .JCE       (JCE),
        .JRTI      (JRTI),
        .JTDO      (JTDO),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_be    (cmd_be),
        .cmd_burst (cmd_burst),
        .cmd_wdata (cmd_wdata),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data)
    );

    always #5 JTCK = ~JTCK;

    always @(posedge JTCK) begin
        if (cmd_valid && cmd_ready) hs_count++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge JTCK);
        #1;
    endtask

    // Capture cap_reg, shift in {pay, op} while recording JTDO, then pulse JUPDATE.
    task automatic xfer(input logic [3:0] op, input logic [31:0] pay,
                        input logic push, input logic [31:0] pdata,
                        output logic [35:0] out);
        logic [35:0] v;
        v = {pay, op};
        JCE = 1'b1; JSHIFT = 1'b0;
        tick;
        JSHIFT = 1'b1;
        for (int i = 0; i < 36; i++) begin
            out[i] = JTDO;
            JTDI = v[i];
            tick;
        end
        JCE = 1'b0; JSHIFT = 1'b0; JTDI = 1'b0; JUPDATE = 1'b1;
        if (push) begin
            rd_valid = 1'b1; rd_data = pdata;
        end
        tick;
        JUPDATE = 1'b0; rd_valid = 1'b0;
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] pay);
        logic [35:0] dummy;
        xfer(op, pay, 1'b0, 32'h0, dummy);
    endtask

    task automatic push_word(input logic [31:0] d);
        rd_valid = 1'b1; rd_data = d;
        tick;
        rd_valid = 1'b0;
    endtask

    task automatic status_check(input string tag, input logic [31:0] exp);
        logic [35:0] out;
        run_op(4'h8, 32'h0);
        xfer(4'h0, 32'h0, 1'b0, 32'h0, out);
        check(tag, {28'h0, out}, {28'h0, exp, 4'h0});
    endtask

    initial begin
        JRSTN = 1'b0; JTDI = 1'b0; JSHIFT = 1'b0; JUPDATE = 1'b0; JCE = 1'b0;
        JRTI = 1'b1; cmd_ready = 1'b0; rd_valid = 1'b0; rd_data = '0;
        tick; tick;
        check("rst_valid", {63'h0, cmd_valid}, 64'h0);
        check("rst_write", {63'h0, cmd_write}, 64'h0);
        check("rst_addr",  {32'h0, cmd_addr},  64'h0);
        check("rst_be",    {60'h0, cmd_be},    64'hF);
        check("rst_burst", {56'h0, cmd_burst}, 64'h0);
        check("rst_wdata", {32'h0, cmd_wdata}, 64'h0);
        check("rst_tdo",   {63'h0, JTDO},      64'h0);
        JRSTN = 1'b1;
        tick;

        run_op(4'h1, 32'h5555_5555);
        check("addr_load", {32'h0, cmd_addr}, 64'h5555_5555);
        run_op(4'h2, 32'h0000_0003);
        check("be_load", {60'h0, cmd_be}, 64'h3);
        run_op(4'h3, 32'h0000_0004);
        check("burst_load", {56'h0, cmd_burst}, 64'h4);

        // Read burst of 4 returned, then popped and shifted out.
        cmd_ready = 1'b1;
        run_op(4'h9, 32'h0);
        check("rd_issue_valid", {63'h0, cmd_valid}, 64'h1);
        check("rd_issue_write", {63'h0, cmd_write}, 64'h0);
        tick;
        check("rd_hs_valid_low", {63'h0, cmd_valid}, 64'h0);
`ifdef JTAG_CHAIN_AUTOINC_EN
        check("rd_addr_after", {32'h0, cmd_addr}, 64'h5555_5565);
`else
        check("rd_addr_after", {32'h0, cmd_addr}, 64'h5555_5555);
`endif
        for (int i = 0; i < 4; i++) push_word(32'hA000_0000 | i);
        status_check("burst4_status", 32'h0000_0400);
        run_op(4'hA, 32'h0);
        for (int i = 0; i < 4; i++) begin
            xfer((i < 3) ? 4'hA : 4'h0, 32'h0, 1'b0, 32'h0, cap);
            check($sformatf("pop_A%0d", i), {28'h0, cap}, {28'h0, 32'hA000_0000 | i, 4'h0});
        end

        // Burst of 10 into an 8-deep buffer.
        run_op(4'h3, 32'd10);
        run_op(4'h9, 32'h0);
        tick;
        for (int i = 0; i < 10; i++) push_word(32'h100 + i);
        check("ovf_valid", {63'h0, cmd_valid}, 64'h0);
        status_check("ovf_status", 32'h0000_0822);
        run_op(4'hF, 32'h0);
        status_check("flush_status", 32'h0000_0004);

        // Stalled write followed by a second write that must be dropped.
        cmd_ready = 1'b0;
        hs_base = hs_count;
        run_op(4'h4, 32'hDEAD_BEEF);
        check("wr_valid", {63'h0, cmd_valid}, 64'h1);
        check("wr_write", {63'h0, cmd_write}, 64'h1);
        check("wr_be",    {60'h0, cmd_be},    64'h3);
        run_op(4'h4, 32'h1234_5678);
        check("wr_hold_wdata", {32'h0, cmd_wdata}, 64'hDEAD_BEEF);
        check("wr_hold_valid", {63'h0, cmd_valid}, 64'h1);
        cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick;
        check("wr_one_hs", 64'(hs_count - hs_base), 64'h1);
        check("wr_done_valid", {63'h0, cmd_valid}, 64'h0);
        status_check("drop_status", 32'h0000_000C);

        // Underflow, then clear.
        run_op(4'hF, 32'h0);
        run_op(4'hA, 32'h0);
        xfer(4'h8, 32'h0, 1'b0, 32'h0, cap);
        check("unf_cap_zero", {28'h0, cap}, 64'h0);
        xfer(4'h0, 32'h0, 1'b0, 32'h0, cap);
        check("unf_status", {28'h0, cap}, {28'h0, 32'h0000_0014, 4'h0});
        run_op(4'hF, 32'h0);
        status_check("clear_status", 32'h0000_0004);

        // JRTI low gates issue without drop.
        JRTI = 1'b0; cmd_ready = 1'b0;
        run_op(4'h4, 32'h0000_1111);
        check("rti_gate_valid", {63'h0, cmd_valid}, 64'h0);
        JRTI = 1'b1;

        // Push and pop together on an empty buffer.
        xfer(4'hA, 32'h0, 1'b1, 32'hCAFE_F00D, junk);
        xfer(4'h8, 32'h0, 1'b0, 32'h0, cap);
        check("bypass_cap", {28'h0, cap}, {28'h0, 32'hCAFE_F00D, 4'h0});
        xfer(4'h0, 32'h0, 1'b0, 32'h0, cap);
        check("bypass_status", {28'h0, cap}, {28'h0, 32'h0000_0004, 4'h0});

        // Address behaviour across a read handshake near the top of the space.
        cmd_ready = 1'b1;
        run_op(4'h1, 32'hFFFF_FFFC);
        run_op(4'h3, 32'h2);
        run_op(4'h9, 32'h0);
        check("inc_burst", {56'h0, cmd_burst}, 64'h2);
        tick;
        push_word(32'h11);
        push_word(32'h22);
`ifdef JTAG_CHAIN_AUTOINC_EN
        check("inc_addr", {32'h0, cmd_addr}, 64'h0000_0004);
`else
        check("inc_addr", {32'h0, cmd_addr}, 64'hFFFF_FFFC);
`endif

        // Reset aborts an outstanding read; later rd_valid words are stored.
        cmd_ready = 1'b0;
        run_op(4'h9, 32'h0);
        check("abort_pending", {63'h0, cmd_valid}, 64'h1);
        JRSTN = 1'b0;
        tick;
        JRSTN = 1'b1;
        check("abort_valid", {63'h0, cmd_valid}, 64'h0);
        check("abort_addr",  {32'h0, cmd_addr},  64'h0);
        check("abort_be",    {60'h0, cmd_be},    64'hF);
        check("abort_burst", {56'h0, cmd_burst}, 64'h0);
        push_word(32'h77);
        status_check("abort_status", 32'h0000_0100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/jtag_cmd_chain.md
JTAG_CMD_CHAIN -- requirements
Module: jtag_cmd_chain

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data/address field width, 8..64, multiple of 8.
REQ-002 SHALL have parameter BUF_DEPTH, default 8: read-buffer entries, power of two, 2..64.
REQ-003 SHALL have parameter BURST_W, default 8: burst-size register width.
REQ-004 SHALL have port JTCK, in, 1: sole clock; all state changes on its rising edge.
REQ-005 SHALL have port JRSTN, in, 1: reset, synchronous, active-low.
REQ-006 SHALL have ports JTDI in 1, JSHIFT in 1, JUPDATE in 1, JCE in 1, JRTI in 1: JTAGG user-chain controls.
REQ-007 SHALL have port JTDO, out, 1: serial data out, equal to shift register bit 0.
REQ-008 SHALL have ports cmd_valid out 1, cmd_ready in 1, cmd_write out 1, cmd_addr out DATA_W, cmd_be out DATA_W/8, cmd_burst out BURST_W, cmd_wdata out DATA_W: bus command.
REQ-009 SHALL have ports rd_valid in 1, rd_data in DATA_W: read-data return, one word per cycle.

Function
REQ-010 SHALL use a shift register sr of 4+DATA_W bits; opcode is sr[3:0], payload is sr[4+DATA_W-1:4].
REQ-011 With JCE=1 and JSHIFT=1, SHALL shift LSB-first: sr <= {JTDI, sr[top:1]}.
REQ-012 With JCE=1 and JSHIFT=0 (capture), SHALL load sr = {cap_reg, 4'h0}.
REQ-013 On a cycle with JUPDATE=1, SHALL decode the opcode; the effect is visible in the next cycle.
REQ-014 Opcode 1 SHALL load the address register from the payload.
REQ-015 Opcode 2 SHALL load byte-enable from the payload LSBs.
REQ-016 Opcode 3 SHALL load burst size from the payload LSBs; a value of 0 is treated as 1.
REQ-017 Opcode 4 SHALL issue a write command with wdata = payload.
REQ-018 Opcode 9 SHALL issue a read command of burst words.
REQ-019 Opcode A SHALL pop the buffer head into cap_reg; on an empty buffer it SHALL set sticky underflow and load cap_reg = 0.
REQ-020 Opcode 8 SHALL load cap_reg with the status word: {0.., overflow[bit5], underflow[bit4], drop[bit3], buf_empty[bit2], buf_full[bit1], busy[bit0]}, with buf_count in bits [15:8].
REQ-021 Opcode F SHALL clear the sticky flags and flush the buffer.
REQ-022 All other opcodes SHALL be no-ops.
REQ-023 The command SHALL use a valid/ready handshake: cmd_valid rises the cycle after the issuing JUPDATE; all cmd_* outputs are held stable until the cycle in which cmd_valid and cmd_ready are both 1.
REQ-024 cmd_valid SHALL fall on the cycle after that handshake cycle.
REQ-025 busy SHALL be 1 from the issue until the handshake for a write, and until burst rd_valid words have been received for a read.
REQ-026 Opcode 4 or 9 received while busy SHALL be dropped and SHALL set sticky drop.
REQ-027 Each rd_valid SHALL push rd_data into the FIFO.
REQ-028 rd_valid on a full FIFO SHALL discard the word, set sticky overflow, and still count toward burst completion.
REQ-029 A push and a pop in the same cycle SHALL leave buf_count unchanged; on an empty FIFO a simultaneous push and pop SHALL pop the pushed word.
REQ-030 FIFO pointers SHALL wrap modulo BUF_DEPTH; buf_count SHALL range 0..BUF_DEPTH.
REQ-031 JRTI SHALL gate issue: opcode 4 or 9 with JRTI=0 on the JUPDATE cycle SHALL be ignored without setting drop.

Reset
REQ-032 While JRSTN=0 at a clock edge, SHALL clear sr, cap_reg, address, burst, busy, the sticky flags and the FIFO pointers; SHALL set byte-enable to all ones.
REQ-033 After reset, outputs SHALL be cmd_valid=0, cmd_write=0, cmd_addr=0, cmd_be=all ones, cmd_burst=0, cmd_wdata=0, and JTDO=0.
REQ-034 Reset during an outstanding command SHALL abort it; rd_valid words arriving after reset SHALL be pushed normally.

Configuration
REQ-035 With macro JTAG_CHAIN_AUTOINC_EN defined, the address register SHALL advance by burst*(DATA_W/8) in the cycle after each read/write handshake, wrapping modulo 2^DATA_W.
REQ-036 Without JTAG_CHAIN_AUTOINC_EN, the address register SHALL change only via opcode 1 or reset.

Verification
REQ-037 Shift opcode 1 with payload 0x55555555 then JUPDATE -> next cycle cmd_addr=0x55555555.
REQ-038 Opcode 3 with payload 4, then opcode 9, cmd_ready=1, 4 rd_valid words A0..A3 -> busy falls, buf_count=4; four opcode-A pops plus captures shift out A0..A3 on JTDO, LSB-first after 4 zero bits.
REQ-039 BUF_DEPTH=8, burst 10 -> buf_count=8, overflow=1, busy=0; opcode 8 capture shows 0x0822 in status bits [15:0].
REQ-040 Opcode 4 with cmd_ready=0, then a second opcode 4 -> cmd_wdata holds the first payload, drop=1, and exactly one handshake occurs.
REQ-041 Opcode A on an empty buffer -> captured payload 0, underflow=1; opcode F -> all flags 0.
REQ-042 With JTAG_CHAIN_AUTOINC_EN, DATA_W=32, burst 2, address 0xFFFFFFFC, one read -> address becomes 0x00000004.
